mul_share_arbiter: RTL and testbench
====================================

MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the multiplier.
REQ-002 Parameter TAG_W, default 4: width of the per-request tag returned with the result.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 reset  input  1: reset is synchronous and active-high.
REQ-005 req_valid  input  NUM_REQ: per-requester request valid.
REQ-006 req_ready  output  NUM_REQ: per-requester accept; at most one bit high per cycle.
REQ-007 req_a  input  NUM_REQ*16: signed operand A, requester i at bits [16i+15:16i].
REQ-008 req_b  input  NUM_REQ*16: signed operand B, same packing.
REQ-009 req_tag  input  NUM_REQ*TAG_W: opaque tag, same packing.
REQ-010 rsp_valid  output  1: result valid.
REQ-011 rsp_ready  input  1: result consumer ready.
REQ-012 rsp_data  output  24: signed product.
REQ-013 rsp_id  output  clog2(NUM_REQ): index of the originating requester.
REQ-014 rsp_tag  output  TAG_W: tag of the originating request.
REQ-015 busy  output  1: high while any accepted request has not yet been handed off.

Function
REQ-016 Transfer on requester i SHALL occur when req_valid[i] && req_ready[i].
REQ-017 Arbitration SHALL be round-robin: search starts at last-granted index + 1 and wraps modulo NUM_REQ; the first requester with req_valid high is granted.
REQ-018 The last-granted pointer SHALL update only in cycles with a transfer.
REQ-019 req_ready SHALL be combinational from req_valid, the pointer, and the stall signal; no bit asserts when the block is stalled.
REQ-020 stall = rsp_valid && !rsp_ready; the multiplier ce = !stall; while stalled, all pipeline state (operands, products, valid/id/tag sideband) SHALL hold.
REQ-021 Multiplier latency SHALL be MUL_LAT = 3 ce-enabled edges from operand capture to product.
REQ-022 A 3-deep valid/id/tag sideband shift register SHALL advance in lockstep with the multiplier; non-transfer cycles insert bubbles (valid=0).
REQ-023 Output register SHALL load {product, id, tag} and set rsp_valid when the last sideband stage is valid and not stalled.
REQ-024 Output register SHALL clear rsp_valid on handoff when no new result arrives in the same cycle.
REQ-025 Request-to-rsp_valid latency SHALL be 4 cycles with no stall, giving a throughput of 1 result/cycle sustained.
REQ-026 rsp_data SHALL be the low 24 bits of the full 32-bit signed product (wrap, no saturation).
REQ-027 Results SHALL be returned in acceptance order, with none dropped or duplicated under any rsp_ready pattern.
REQ-028 busy SHALL equal rsp_valid OR any sideband valid bit.
REQ-029 Requests with req_valid dropped before transfer SHALL be ignored; no state is left from them.

Reset
REQ-030 On reset: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_tag=0, busy=0, all sideband valid bits=0, pointer=NUM_REQ-1 (requester 0 highest priority first).
REQ-031 Reset mid-operation SHALL discard all in-flight requests; no rsp_valid is generated from them.
REQ-032 req_ready SHALL be 0 while reset is high.

Structure
REQ-033 Package mul_share_pkg SHALL hold MUL_LAT, the operand width (16), the product width (24), and the sideband struct type {valid, id, tag}.
REQ-034 The datapath SHALL be one instance of the team's TOP_mul_mul_16s_16s_24_4_1 multiplier, with ce driven per REQ-020.
REQ-035 No other sub-modules; arbiter, sideband and output register live in mul_share_arbiter.

Verification
REQ-036 Single request: requester 2 sends a=300, b=-7, tag=5 at cycle 0 -> rsp_valid at cycle 4 with data=-2100, id=2, tag=5; busy high for cycles 1-4.
REQ-037 All requesters hold valid continuously after reset -> grants in order 0,1,2,3,0,...; one result per cycle in that order.
REQ-038 Wrap: a=b=-32768 -> rsp_data=0x000000 (low 24 bits of 0x40000000); a=32767, b=2 -> 65534.
REQ-039 Backpressure: rsp_ready low for 5 cycles during streaming -> req_ready all 0 and outputs stable; after release the sequence is complete and in order.
REQ-040 Reset asserted with 3 requests in flight -> no rsp_valid afterwards, busy=0 after the reset edge, and the next grant goes to requester 0.
REQ-041 Random valid/rsp_ready over 10k cycles, checked against a scoreboard model -> every accepted request returns exactly once with the correct product, id and tag.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared widths, multiplier latency and the sideband record carried alongside
// each operand pair through the shared multiplier pipeline.
package mul_share_pkg;

    localparam int unsigned MUL_LAT  = 3;
    localparam int unsigned OPND_W   = 16;
    localparam int unsigned PROD_W   = 24;

    // Sideband fields are sized for the widest supported configuration and
    // narrowed at the point of use.
    localparam int unsigned SB_ID_W  = 8;
    localparam int unsigned SB_TAG_W = 16;

    typedef struct packed {
        logic                valid;
        logic [SB_ID_W-1:0]  id;
        logic [SB_TAG_W-1:0] tag;
    } sideband_t;

endpackage

// File: rtl/TOP_mul_mul_16s_16s_24_4_1.sv
// Pipelined 16x16 signed multiplier returning the low 24 product bits.
// Operands are captured on one ce edge; the product is valid MUL_LAT ce edges after that capture.
module TOP_mul_mul_16s_16s_24_4_1
    import mul_share_pkg::*;
(
    input  logic              clk,
    input  logic              ce,
    input  logic [OPND_W-1:0] din0,
    input  logic [OPND_W-1:0] din1,
    output logic [PROD_W-1:0] dout
);

    localparam int unsigned PIPE_N = MUL_LAT - 1;

    logic [OPND_W-1:0]        a_q, a_d;
    logic [OPND_W-1:0]        b_q, b_d;
    logic [PROD_W-1:0]        pipe_q [PIPE_N];
    logic [PROD_W-1:0]        pipe_d [PIPE_N];
    logic signed [PROD_W-1:0] a_ext, b_ext;

    // Sign-extending to the product width first makes the 24-bit multiply
    // produce exactly the low 24 bits of the full 32-bit product.
    always_comb begin
        a_ext = {{(PROD_W-OPND_W){a_q[OPND_W-1]}}, a_q};
        b_ext = {{(PROD_W-OPND_W){b_q[OPND_W-1]}}, b_q};
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        pipe_d = pipe_q;
        if (ce) begin
            a_d       = din0;
            b_d       = din1;
            pipe_d[0] = a_ext * b_ext;
            for (int unsigned i = 1; i < PIPE_N; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        pipe_q <= pipe_d;
    end

    always_comb begin
        dout = pipe_q[PIPE_N-1];
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one pipelined signed multiplier among NUM_REQ requesters.
// Results return in acceptance order with the originating requester id and tag.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned TAG_W   = 4,
    localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OPND_W-1:0] req_a,
    input  logic [NUM_REQ*OPND_W-1:0] req_b,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [PROD_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic [TAG_W-1:0]          rsp_tag,
    output logic                      busy
);

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand;
    logic              grant_found;
    logic              stall;
    logic              ce;
    logic              transfer;

    logic [OPND_W-1:0] op_a, op_b;
    logic [TAG_W-1:0]  op_tag;
    logic [PROD_W-1:0] mul_dout;

    sideband_t         sb_new;
    sideband_t         sb_q [MUL_LAT];
    sideband_t         sb_d [MUL_LAT];

    logic              rsp_valid_q, rsp_valid_d;
    logic [PROD_W-1:0] rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;

    logic              unused_sb_bits;

    always_comb begin
        stall = rsp_valid_q && !rsp_ready;
        ce    = !stall;
    end

    // Search starts one past the last grant and wraps modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        transfer  = grant_found && !stall && !reset;
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = transfer && (grant_idx == ID_W'(i));
        end
        ptr_d = transfer ? grant_idx : ptr_q;
    end

    always_comb begin
        op_a   = req_a[32'(grant_idx)*OPND_W +: OPND_W];
        op_b   = req_b[32'(grant_idx)*OPND_W +: OPND_W];
        op_tag = req_tag[32'(grant_idx)*TAG_W +: TAG_W];
    end

    TOP_mul_mul_16s_16s_24_4_1 u_mul (
        .clk  (clk),
        .ce   (ce),
        .din0 (op_a),
        .din1 (op_b),
        .dout (mul_dout)
    );

    // Sideband advances on the same ce as the multiplier; idle cycles push bubbles.
    always_comb begin
        sb_new.valid = transfer;
        sb_new.id    = SB_ID_W'(grant_idx);
        sb_new.tag   = SB_TAG_W'(op_tag);
        sb_d         = sb_q;
        if (ce) begin
            sb_d[0] = sb_new;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                sb_d[i] = sb_q[i-1];
            end
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_tag_d   = rsp_tag_q;
        if (!stall) begin
            rsp_valid_d = sb_q[MUL_LAT-1].valid;
            if (sb_q[MUL_LAT-1].valid) begin
                rsp_data_d = mul_dout;
                rsp_id_d   = sb_q[MUL_LAT-1].id[ID_W-1:0];
                rsp_tag_d  = sb_q[MUL_LAT-1].tag[TAG_W-1:0];
            end
        end
    end

    always_comb begin
        unused_sb_bits = ^{sb_q[MUL_LAT-1].id, sb_q[MUL_LAT-1].tag};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= ID_W'(NUM_REQ - 1);
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                sb_q[i] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_tag_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            sb_q        <= sb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

    always_comb begin
        busy = rsp_valid_q;
        for (int unsigned i = 0; i < MUL_LAT; i++) begin
            busy = busy | sb_q[i].valid;
        end
        rsp_valid = rsp_valid_q;
        rsp_data  = rsp_data_q;
        rsp_id    = rsp_id_q;
        rsp_tag   = rsp_tag_q;
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: a round-robin reference model queues
// expected results at acceptance; a separate monitor checks them at handoff.
module tb_mul_share_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [15:0] req_tag = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [23:0] rsp_data;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_tag;
    logic        busy;

    mul_share_arbiter #(.NUM_REQ(4), .TAG_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_tag   (rsp_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] data;
        int          id;
        logic [3:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t me;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mptr = 3;
    int   acc_now = 0;
    bit   in_rst = 1'b1;
    bit   started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [23:0] prod24(input logic signed [15:0] a, input logic signed [15:0] b);
        int p;
        p = int'(a) * int'(b);
        return p[23:0];
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    // One clock cycle of stimulus plus the reference model's acceptance decision.
    task automatic step(input logic rst, input logic [3:0] v, input logic rr,
                        input logic [63:0] a, input logic [63:0] b, input logic [15:0] tg);
        int         g;
        int         idx;
        logic [3:0] exp_rdy;
        exp_t       e;
        @(negedge clk);
        reset     = rst;
        req_valid = v;
        rsp_ready = rr;
        req_a     = a;
        req_b     = b;
        req_tag   = tg;
        #1;
        started = 1'b1;
        g = -1;
        if (!rst && !(rsp_valid && !rr)) begin
            for (int k = 1; k <= 4; k++) begin
                idx = (mptr + k) % 4;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        acc_now = 0;
        in_rst  = rst;
        if (rst) begin
            exp_q.delete();
            mptr = 3;
        end else if (g >= 0) begin
            e.data = prod24(a[16*g +: 16], b[16*g +: 16]);
            e.id   = g;
            e.tag  = tg[4*g +: 4];
            exp_q.push_back(e);
            mptr    = g;
            acc_now = 1;
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (started && !in_rst) begin
            chk("busy", 32'(busy), 32'((exp_q.size() - acc_now) > 0));
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_extra: got id %0d data %0h expected no response at %0t",
                             rsp_id, rsp_data, $time);
                end else begin
                    me = exp_q.pop_front();
                    chk("rsp_data", 32'(rsp_data), 32'(me.data));
                    chk("rsp_id", 32'(rsp_id), 32'(me.id));
                    chk("rsp_tag", 32'(rsp_tag), 32'(me.tag));
                end
            end
        end
    end

    initial begin
        logic [63:0] la, lb;
        logic [15:0] lt;
        logic [23:0] hd;
        logic [1:0]  hid;
        logic [3:0]  htag;
        int          guard;

        // Reset state
        repeat (3) step(1'b1, 4'b1111, 1'b1, r64(), r64(), 16'($urandom));
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_data", 32'(rsp_data), 0);
        chk("rst_id", 32'(rsp_id), 0);
        chk("rst_tag", 32'(rsp_tag), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(req_ready), 0);

        // Single request from requester 2: 300 * -7 with tag 5
        la = r64(); lb = r64(); lt = 16'($urandom);
        la[47:32] = 16'd300;
        lb[47:32] = 16'hFFF9;
        lt[11:8]  = 4'd5;
        step(1'b0, 4'b0100, 1'b1, la, lb, lt);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 4'b0000, 1'b1, r64(), r64(), 16'($urandom));
            chk("single_lat", 32'(rsp_valid), 32'(k == 4));
        end
        chk("single_data", 32'(rsp_data), 32'h00FFF7CC);
        chk("single_id", 32'(rsp_id), 2);
        chk("single_tag", 32'(rsp_tag), 5);
        step(1'b0, 4'b0000, 1'b1, r64(), r64(), 16'($urandom));
        chk("single_done", 32'(rsp_valid), 0);

        // All requesters valid from reset: 0,1,2,3,0,...
        repeat (2) step(1'b1, 4'b0000, 1'b1, r64(), r64(), 16'($urandom));
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 4'b1111, 1'b1, r64(), r64(), 16'($urandom));
            chk("rr_order", 32'(req_ready), 32'(1 << (k % 4)));
        end
        repeat (6) step(1'b0, 4'b0000, 1'b1, r64(), r64(), 16'($urandom));

        // Wrap-around products
        repeat (2) step(1'b1, 4'b0000, 1'b1, r64(), r64(), 16'($urandom));
        la = r64(); lb = r64();
        la[15:0] = 16'h8000; lb[15:0] = 16'h8000;
        la[31:16] = 16'h7FFF; lb[31:16] = 16'h0002;
        step(1'b0, 4'b0011, 1'b1, la, lb, 16'($urandom));
        step(1'b0, 4'b0011, 1'b1, la, lb, 16'($urandom));
        step(1'b0, 4'b0000, 1'b1, r64(), r64(), 16'($urandom));
        step(1'b0, 4'b0000, 1'b1, r64(), r64(), 16'($urandom));
        step(1'b0, 4'b0000, 1'b1, r64(), r64(), 16'($urandom));
        chk("wrap_min_valid", 32'(rsp_valid), 1);
        chk("wrap_min", 32'(rsp_data), 32'h0);
        step(1'b0, 4'b0000, 1'b1, r64(), r64(), 16'($urandom));
        chk("wrap_max", 32'(rsp_data), 32'd65534);
        repeat (3) step(1'b0, 4'b0000, 1'b1, r64(), r64(), 16'($urandom));

        // Backpressure during streaming
        repeat (6) step(1'b0, 4'b1111, 1'b1, r64(), r64(), 16'($urandom));
        step(1'b0, 4'b1111, 1'b0, r64(), r64(), 16'($urandom));
        hd = rsp_data; hid = rsp_id; htag = rsp_tag;
        chk("bp_valid", 32'(rsp_valid), 1);
        for (int k = 1; k < 5; k++) begin
            step(1'b0, 4'b1111, 1'b0, r64(), r64(), 16'($urandom));
            chk("bp_ready", 32'(req_ready), 0);
            chk("bp_data", 32'(rsp_data), 32'(hd));
            chk("bp_id", 32'(rsp_id), 32'(hid));
            chk("bp_tag", 32'(rsp_tag), 32'(htag));
        end
        repeat (10) step(1'b0, 4'b0000, 1'b1, r64(), r64(), 16'($urandom));
        chk("bp_drained", 32'(exp_q.size()), 0);

        // Reset with three requests in flight
        repeat (3) step(1'b0, 4'b1111, 1'b1, r64(), r64(), 16'($urandom));
        step(1'b1, 4'b1111, 1'b1, r64(), r64(), 16'($urandom));
        step(1'b0, 4'b1111, 1'b1, r64(), r64(), 16'($urandom));
        chk("rst_mid_grant", 32'(req_ready), 1);
        chk("rst_mid_busy", 32'(busy), 0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'b0000, 1'b1, r64(), r64(), 16'($urandom));
            chk("rst_mid_quiet", 32'(rsp_valid), 0);
        end
        repeat (4) step(1'b0, 4'b0000, 1'b1, r64(), r64(), 16'($urandom));

        // Random traffic and backpressure
        for (int k = 0; k < 10000; k++) begin
            step(1'b0, 4'($urandom), ($urandom % 4) != 0, r64(), r64(), 16'($urandom));
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 60) begin
            step(1'b0, 4'b0000, 1'b1, r64(), r64(), 16'($urandom));
            guard++;
        end
        chk("final_drain", 32'(exp_q.size()), 0);
        step(1'b0, 4'b0000, 1'b1, r64(), r64(), 16'($urandom));
        chk("final_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
